// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the 16-bit datapath ALU.
//   WIDTH       - operand/result width
//   alu_op_e    - operation encoding carried on the 3-bit op port
//   alu_flags_t - status flag set {z, n, c, v}
package alu_pkg;

   localparam int WIDTH = 16;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SHL = 3'd5,
      ALU_SRA = 3'd6,
      ALU_SLT = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: shared adder/subtractor for ADD, SUB and SLT.
//   a, b     - operands
//   sub      - 1 selects a - b, 0 selects a + b
//   sum      - result mod 2^WIDTH
//   carry    - carry out for add; borrow (unsigned a < b) for subtract
//   overflow - signed overflow of the selected operation
module alu_addsub
   import alu_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         carry,
   output logic         overflow
);

   logic [W-1:0] b_eff;
   logic [W:0]   full;

   // Subtraction as a + ~b + 1 so one adder serves both operations.
   assign b_eff = sub ? ~b : b;
   assign full  = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
   assign sum   = full[W-1:0];

   // With a + ~b + 1 the carry out is "no borrow", so invert it for subtract.
   assign carry = sub ? ~full[W] : full[W];

   // Comparing against b_eff folds both rules into one: for subtract, a and ~b
   // share a sign exactly when a and b differ.
   assign overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/alu.sv
// alu: 16-bit signed ALU with a registered status-flag set.
//   clk, rst      - clock and synchronous active-high reset (flag register only)
//   op            - operation select (see alu_op_e)
//   lhs, rhs      - signed operands
//   result        - combinational result, independent of clk and rst
//   flags_we      - capture the current operation's flags on the next rising edge
//   flag_z/n/c/v  - registered zero, negative, carry/borrow, overflow flags
// There is no handshake: result follows the inputs in the same time step and
// flags are written unconditionally on any edge where flags_we is high.
module alu
   import alu_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   op,
   input  logic [W-1:0] lhs,
   input  logic [W-1:0] rhs,
   output logic [W-1:0] result,
   input  logic         flags_we,
   output logic         flag_z,
   output logic         flag_n,
   output logic         flag_c,
   output logic         flag_v
);

   alu_op_e    op_e;
   logic       use_sub;
   logic [W-1:0] as_sum;
   logic       as_carry;
   logic       as_ovf;
   logic [3:0] shamt;
   logic [W:0] shl_full;
   logic [W:0] sra_full;
   logic       c_nxt;
   logic       v_nxt;
   alu_flags_t flags_nxt;
   alu_flags_t flags_q;

   assign op_e    = alu_op_e'(op);
   assign use_sub = (op_e == ALU_SUB) || (op_e == ALU_SLT);

   alu_addsub #(.W(W)) u_addsub (
      .a        (lhs),
      .b        (rhs),
      .sub      (use_sub),
      .sum      (as_sum),
      .carry    (as_carry),
      .overflow (as_ovf)
   );

   // Only rhs[3:0] matters. Each shift is done one bit wider so the last bit
   // shifted out lands in the extra bit; with a zero amount that bit stays 0.
   assign shamt    = rhs[3:0];
   assign shl_full = {1'b0, lhs} << shamt;
   assign sra_full = $signed({lhs, 1'b0}) >>> shamt;

   always_comb begin
      result = '0;
      c_nxt  = 1'b0;
      v_nxt  = 1'b0;
      case (op_e)
         ALU_ADD: begin
            result = as_sum;
            c_nxt  = as_carry;
            v_nxt  = as_ovf;
         end
         ALU_SUB: begin
            result = as_sum;
            c_nxt  = as_carry;
            v_nxt  = as_ovf;
         end
         ALU_AND: result = lhs & rhs;
         ALU_OR:  result = lhs | rhs;
         ALU_XOR: result = lhs ^ rhs;
         ALU_SHL: begin
            result = shl_full[W-1:0];
            c_nxt  = shl_full[W];
         end
         ALU_SRA: begin
            result = sra_full[W:1];
            c_nxt  = sra_full[0];
         end
         // Signed less-than: difference sign corrected by overflow.
         ALU_SLT: result = {{(W-1){1'b0}}, as_sum[W-1] ^ as_ovf};
         default: result = '0;
      endcase
   end

   always_comb begin
      flags_nxt   = '0;
      flags_nxt.z = (result == '0);
      flags_nxt.n = result[W-1];
      flags_nxt.c = c_nxt;
      flags_nxt.v = v_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else if (flags_we) begin
         flags_q <= flags_nxt;
      end
   end

   assign flag_z = flags_q.z;
   assign flag_n = flags_q.n;
   assign flag_c = flags_q.c;
   assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic [2:0]   op;
   logic [W-1:0] lhs;
   logic [W-1:0] rhs;
   logic [W-1:0] result;
   logic         flags_we;
   logic         flag_z;
   logic         flag_n;
   logic         flag_c;
   logic         flag_v;

   alu dut (
      .clk      (clk),
      .rst      (rst),
      .op       (op),
      .lhs      (lhs),
      .rhs      (rhs),
      .result   (result),
      .flags_we (flags_we),
      .flag_z   (flag_z),
      .flag_n   (flag_n),
      .flag_c   (flag_c),
      .flag_v   (flag_v)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard
   logic [W-1:0] exp_q[$];
   int           kind_q[$];   // 0: result, 1: flags {z,n,c,v}
   string        name_q[$];
   int           n_compared = 0;
   int           n_mismatched = 0;
   event         sample_ev;

   initial begin
      forever begin
         @(sample_ev);
         while (exp_q.size() > 0) begin
            logic [W-1:0] exp_v;
            logic [W-1:0] act_v;
            int           kind;
            string        nm;
            exp_v = exp_q.pop_front();
            kind  = kind_q.pop_front();
            nm    = name_q.pop_front();
            if (kind == 0) act_v = result;
            else           act_v = {12'b0, flag_z, flag_n, flag_c, flag_v};
            n_compared++;
            if (act_v !== exp_v) begin
               n_mismatched++;
               $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [W-1:0] l, input logic [W-1:0] r);
      op  = o;
      lhs = l;
      rhs = r;
      #1;
   endtask

   task automatic expect_result(input logic [W-1:0] e, input string nm);
      exp_q.push_back(e);
      kind_q.push_back(0);
      name_q.push_back(nm);
      -> sample_ev;
      #1;
   endtask

   // e is {z, n, c, v}
   task automatic expect_flags(input logic [3:0] e, input string nm);
      exp_q.push_back({12'b0, e});
      kind_q.push_back(1);
      name_q.push_back(nm);
      -> sample_ev;
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      flags_we = 1'b0;
      op       = 3'd0;
      lhs      = '0;
      rhs      = '0;
      tick();
      tick();
      rst = 1'b0;
      expect_flags(4'b0000, "reset_flags");

      // ADD sweep, combinational only
      for (int a = 2; a <= 29; a++) begin
         for (int b = 2; b <= 29; b++) begin
            drive(3'd0, W'(a), W'(b));
            expect_result(W'(a + b), "add_sweep");
         end
      end

      // overflow / carry boundaries
      flags_we = 1'b1;
      drive(3'd0, 16'h7FFF, 16'h0001);
      expect_result(16'h8000, "add_ovf_res");
      tick();
      expect_flags(4'b0101, "add_ovf_flags");

      drive(3'd0, 16'hFFFF, 16'h0001);
      expect_result(16'h0000, "add_wrap_res");
      tick();
      expect_flags(4'b1010, "add_wrap_flags");

      drive(3'd1, 16'h8000, 16'h0001);
      expect_result(16'h7FFF, "sub_ovf_res");
      tick();
      expect_flags(4'b0001, "sub_ovf_flags");

      drive(3'd1, 16'd5, 16'd9);
      expect_result(16'hFFFC, "sub_borrow_res");
      tick();
      expect_flags(4'b0110, "sub_borrow_flags");

      // SLT: carry/overflow of the internal subtract must not reach the flags
      drive(3'd7, 16'hFFFD, 16'd2);
      expect_result(16'd1, "slt_neg_pos");
      drive(3'd7, 16'd4, 16'd4);
      expect_result(16'd0, "slt_equal");
      drive(3'd7, 16'd2, 16'hFFFD);
      expect_result(16'd0, "slt_pos_neg");
      tick();
      expect_flags(4'b1000, "slt_flags");

      // logic ops
      drive(3'd2, 16'hF0F0, 16'h0FF0);
      expect_result(16'h00F0, "and");
      drive(3'd3, 16'hF0F0, 16'h0FF0);
      expect_result(16'hFFF0, "or");
      drive(3'd4, 16'hF0F0, 16'h0FF0);
      expect_result(16'hFF00, "xor");

      // shifts (upper rhs bits ignored)
      drive(3'd5, 16'h0001, 16'h0013);
      expect_result(16'h0008, "shl_amt3");
      tick();
      expect_flags(4'b0000, "shl_amt3_flags");
      drive(3'd5, 16'hC000, 16'h0001);
      expect_result(16'h8000, "shl_carry_res");
      tick();
      expect_flags(4'b0110, "shl_carry_flags");
      drive(3'd5, 16'h8001, 16'h0010);
      expect_result(16'h8001, "shl_amt0_res");
      tick();
      expect_flags(4'b0100, "shl_amt0_flags");
      drive(3'd6, 16'h8000, 16'h0004);
      expect_result(16'hF800, "sra_sign");
      tick();
      expect_flags(4'b0100, "sra_sign_flags");
      drive(3'd6, 16'h0003, 16'h0001);
      expect_result(16'h0001, "sra_carry_res");
      tick();
      expect_flags(4'b0010, "sra_carry_flags");

      // reset beats flags_we and does not touch result
      drive(3'd0, 16'h7FFF, 16'h0001);
      tick();
      expect_flags(4'b0101, "pre_reset_flags");
      rst = 1'b1;
      drive(3'd0, 16'hFFFF, 16'h0001);
      expect_result(16'h0000, "result_in_reset");
      tick();
      expect_flags(4'b0000, "reset_over_we");
      rst      = 1'b0;
      flags_we = 1'b0;

      // hold with flags_we low while result tracks inputs
      drive(3'd1, 16'd5, 16'd9);
      expect_result(16'hFFFC, "hold_sub_res");
      tick();
      expect_flags(4'b0000, "hold_zero_a");
      drive(3'd5, 16'hC000, 16'h0001);
      expect_result(16'h8000, "hold_shl_res");
      tick();
      expect_flags(4'b0000, "hold_zero_b");

      flags_we = 1'b1;
      drive(3'd0, 16'h7FFF, 16'h0001);
      tick();
      flags_we = 1'b0;
      drive(3'd2, 16'h0000, 16'hFFFF);
      expect_result(16'h0000, "hold_and_res");
      tick();
      expect_flags(4'b0101, "hold_nonzero_a");
      drive(3'd6, 16'h0003, 16'h0001);
      tick();
      expect_flags(4'b0101, "hold_nonzero_b");

      #2;
      n_compared++;
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit signed arithmetic/logic unit for the CPU datapath.
- Computes `result` combinationally from `op`, `lhs` and `rhs` with zero latency; `result` settles in the same delta/cycle as its inputs.
- Also holds a registered status-flag set (zero, negative, carry, overflow), captured on the clock when enabled, for use by branch/condition logic.

Parameters:
- WIDTH, 16, operand/result width in bits; all behaviour below is stated for 16.

Ports:
- clk, input, 1, rising-edge clock; used only by the flag register.
- rst, input, 1, synchronous active-high reset; clears the flag register.
- op, input, 3, operation select (encoding below).
- lhs, input, 16, signed left operand.
- rhs, input, 16, signed right operand.
- result, output, 16, signed combinational result.
- flags_we, input, 1, when high, flags register captures the current operation's flags at the clock edge.
- flag_z, output, 1, registered zero flag.
- flag_n, output, 1, registered negative flag.
- flag_c, output, 1, registered carry/borrow flag.
- flag_v, output, 1, registered signed-overflow flag.

Behaviour:
- `result` is purely combinational: no clock and no reset dependence; valid the same time step inputs change.
- Op encoding:
  - 0 ADD: lhs + rhs, mod 2^16.
  - 1 SUB: lhs - rhs, mod 2^16.
  - 2 AND: bitwise.
  - 3 OR: bitwise.
  - 4 XOR: bitwise.
  - 5 SHL: lhs << rhs[3:0]; zero fill.
  - 6 SRA: lhs >>> rhs[3:0]; sign fill.
  - 7 SLT: 16'd1 if lhs < rhs (signed), else 16'd0.
- Shift amounts use only rhs[3:0]; rhs[15:4] are ignored (shift by 16 or more is impossible).
- Next-flag computation is combinational:
  - z = (result == 0).
  - n = result[15].
  - c:
    - ADD: carry out of bit 15.
    - SUB: borrow, i.e. unsigned lhs < rhs.
    - SHL: last bit shifted out, or 0 if the shift amount is 0.
    - SRA: last bit shifted out, or 0 if the shift amount is 0.
    - Other ops: 0.
  - v:
    - ADD: operands share a sign and the result's sign differs.
    - SUB: operand signs differ and the result's sign differs from lhs.
    - Other ops: 0.
- Flag register, at rising clk:
  - rst=1: all four flags ← 0. Reset has priority over flags_we.
  - else flags_we=1: flags ← next-flag values.
  - else: hold.
- Flag outputs are 0 from the first clock edge with rst asserted until written.
- rst has no effect on `result`.
- Boundary cases:
  - 32767+1 → result -32768, v=1, c=0.
  - -32768-1 → result 32767, v=1, c=0.
  - -1+1 → result 0, z=1, c=1, v=0.

Decomposition:
- Package `alu_pkg`: typedef enum logic [2:0] alu_op_e {ALU_ADD=0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SRA, ALU_SLT}; typedef struct packed {z,n,c,v} alu_flags_t; localparam WIDTH=16.
- Port `op` stays a plain 3-bit logic vector so benches can drive integer literals.
- One natural sub-module, `alu_addsub`: a 17-bit adder/subtractor producing the sum, carry/borrow and overflow. It is shared by ADD, SUB and SLT.

Test Plan:
- ADD sweep: op=0, lhs and rhs each swept 2..29 independently → result = lhs+rhs (2+2=4, 29+29=58, 13+7=20); checked after #0 with no clock.
- Overflow/carry: op=0, lhs=32767, rhs=1, flags_we=1, one clock → result=-32768; flags z=0 n=1 c=0 v=1. Then lhs=-1, rhs=1 → result=0; after a clock z=1 c=1 v=0.
- SUB/SLT:
  - op=1, 5-9 → -4, c=1 (borrow), n=1.
  - op=7, -3 vs 2 → 1; 2 vs -3 → 0; 4 vs 4 → 0.
- Logic/shift:
  - AND 16'hF0F0 & 16'h0FF0 → 16'h00F0.
  - OR of the same operands → 16'hFFF0.
  - XOR of the same operands → 16'hFF00.
  - SHL 16'h0001 by rhs=16'h0013 (amount 3) → 16'h0008.
  - SRA 16'h8000 by 4 → 16'hF800.
- Reset/flag control:
  - With flags set, assert rst together with flags_we=1 for one edge → all flags 0.
  - Then flags_we=0 with changing ops → flags hold while result keeps tracking the inputs.
